// File: rtl/stride_cnt_pkg.sv
// Shared types and helpers for the stride address counter.
// The STRIDE_CNT_DOWN_EN macro enables down counting in the counter files.
package stride_cnt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stride_state_t;

    // Width of the pass counter: it must be able to hold the value PASSES.
    function automatic int pass_w(input int passes);
        return $clog2(passes + 1);
    endfunction

endpackage

// File: rtl/stride_next.sv
// Combinational next-address and wrap-flag calculation for the stride counter.
// With STRIDE_CNT_DOWN_EN defined, a dir input selects down counting.
module stride_next #(
    parameter int WIDTH     = 10,
    parameter int STEP      = 2,
    parameter int START_VAL = 0,
    parameter int LIMIT     = 1022
) (
    input  logic [WIDTH-1:0] count,
`ifdef STRIDE_CNT_DOWN_EN
    input  logic             dir,
`endif
    output logic [WIDTH-1:0] nxt,
    output logic             wrap
);

    localparam logic [WIDTH:0]   STEP_X  = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   LIMIT_X = (WIDTH+1)'(LIMIT);
    localparam logic [WIDTH-1:0] START_N = WIDTH'(START_VAL);
    localparam logic [WIDTH-1:0] LIMIT_N = WIDTH'(LIMIT);
`ifdef STRIDE_CNT_DOWN_EN
    localparam logic [WIDTH:0]   START_X = (WIDTH+1)'(START_VAL);
    localparam logic [WIDTH-1:0] STEP_N  = WIDTH'(STEP);
`endif

    // Sum is one bit wider so values loaded above LIMIT cannot alias back below it.
    logic [WIDTH:0] sum;
    assign sum = {1'b0, count} + STEP_X;

    // Pick the advanced value, or the wrap target when the stride leaves the legal range.
    always_comb begin
        nxt  = sum[WIDTH-1:0];
        wrap = 1'b0;
        if (sum > LIMIT_X) begin
            nxt  = START_N;
            wrap = 1'b1;
        end
`ifdef STRIDE_CNT_DOWN_EN
        if (dir) begin
            // Compare in WIDTH+1 bits so START_VAL+STEP never overflows.
            if ({1'b0, count} < START_X + STEP_X) begin
                nxt  = LIMIT_N;
                wrap = 1'b1;
            end else begin
                nxt  = count - STEP_N;
                wrap = 1'b0;
            end
        end
`endif
    end

endmodule

// File: rtl/stride_addr_counter.sv
// Run-controlled stride address counter for the NB-LDPC message memories.
// Defining STRIDE_CNT_DOWN_EN adds a dir input (0=up, 1=down).
module stride_addr_counter
    import stride_cnt_pkg::*;
#(
    parameter int WIDTH     = 10,
    parameter int STEP      = 2,
    parameter int START_VAL = 0,
    parameter int LIMIT     = 1022,
    parameter int PASSES    = 1,
    localparam int PW       = pass_w(PASSES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef STRIDE_CNT_DOWN_EN
    input  logic             dir,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic [PW-1:0]    pass,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] START_N  = WIDTH'(START_VAL);
    localparam logic [PW-1:0]    PASSES_N = PW'(PASSES);

    stride_state_t    state;
    logic [WIDTH-1:0] nxt;
    logic             wrap;
    logic [PW-1:0]    pass_inc;

    assign pass_inc = pass + 1'b1;

    stride_next #(
        .WIDTH     (WIDTH),
        .STEP      (STEP),
        .START_VAL (START_VAL),
        .LIMIT     (LIMIT)
    ) u_next (
        .count (count),
`ifdef STRIDE_CNT_DOWN_EN
        .dir   (dir),
`endif
        .nxt   (nxt),
        .wrap  (wrap)
    );

    // Run-control FSM with registered outputs; stop > start > load > enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= START_N;
            tc    <= 1'b0;
            pass  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (stop) begin
                state <= IDLE;
                count <= START_N;
                pass  <= '0;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else if (start) begin
                state <= RUN;
                count <= START_N;
                pass  <= '0;
                busy  <= 1'b1;
                done  <= 1'b0;
            end else if (load) begin
                count <= load_val;
            end else if (enable && state == RUN) begin
                count <= nxt;
                if (wrap) begin
                    tc   <= 1'b1;
                    pass <= pass_inc;
                    if (pass_inc == PASSES_N) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/stride_addr_counter.md
# stride_addr_counter

Parametrised, run-controlled stride counter generating memory addresses for the GF(16) NB-LDPC check-node and variable-node message memories. Generalises the fixed-width even-step counter: configurable width, stride, start, limit and pass count, with wrap-around, terminal-count pulse, parallel load and a small run-control state machine. It sits between the decoder iteration controller, which drives `start`, `stop` and `enable`, and the message RAM address ports, which read `count`.

## Interface
Parameters:
- `WIDTH`, 10: counter width in bits.
- `STEP`, 2: increment per enabled cycle; 1..2^WIDTH-1.
- `START_VAL`, 0: value after reset, start, stop and wrap.
- `LIMIT`, 1022: highest legal count; requires START_VAL <= LIMIT < 2^WIDTH.
- `PASSES`, 1: wraps per run before done; >= 1.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: begin a run; single-cycle pulse.
- `stop` in 1: abort the run.
- `enable` in 1: advance by STEP while in RUN.
- `load` in 1: parallel load of `load_val`.
- `load_val` in WIDTH: load value.
- `count` out WIDTH: current address.
- `tc` out 1: terminal-count pulse, one cycle per wrap.
- `pass` out $clog2(PASSES+1): completed passes in the current run.
- `busy` out 1: high in RUN.
- `done` out 1: high in DONE.

## Operation
- States:
  - IDLE: reset state.
  - RUN: counting.
  - DONE: run finished; count holds.
- Input priority: reset > stop > start > load > enable.
- stop, any state: go to IDLE, count=START_VAL, pass=0.
- start, any state: go to RUN, count=START_VAL, pass=0. A start during RUN restarts the run.
- load, any state: count=load_val. No state change and no pass or tc effect. Loaded values above LIMIT are permitted; the next advance then wraps.
- enable in RUN:
  - nxt = count + STEP, computed in WIDTH+1 bits with no truncation.
  - If nxt <= LIMIT: count=nxt.
  - Otherwise wrap: count=START_VAL, tc=1, pass=pass+1.
  - If the wrap makes pass equal PASSES, go to DONE.
- enable in IDLE or DONE is ignored.
- DONE holds count=START_VAL and pass=PASSES until start or stop arrives.
- If (LIMIT-START_VAL) is not a multiple of STEP, the last value before a wrap is the largest START_VAL+k·STEP that is <= LIMIT.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Reset values: count=START_VAL, tc=0, pass=0, busy=0, done=0, state=IDLE.
- count updates one cycle after the enable, load or start edge.
- tc is high in exactly the cycle where count first shows START_VAL after a wrap. It is low in all other cycles, including after a start.
- busy and done change in the same cycle as the state register.
- Simultaneous start and enable: the start wins and count=START_VAL. The enable is not applied.
- Reset asserted mid-run: all outputs return to reset values immediately; no pass is recorded.

## Configuration
- `STRIDE_CNT_DOWN_EN` defined:
  - Adds input `dir` (1 bit; 0=up, 1=down).
  - Down mode: if count < START_VAL+STEP (borrow-safe compare), wrap to count=LIMIT with tc and pass exactly as in up mode. Otherwise count=count-STEP.
  - start and stop still reset count to START_VAL.
- Undefined: no `dir` port; up-count only.

## Structure
- Package `stride_cnt_pkg`:
  - typedef `stride_state_t` enum {IDLE, RUN, DONE}.
  - localparam function for the pass width, $clog2(PASSES+1).
- One sub-module, `stride_next`: combinational next-value and wrap-flag computation from count, STEP, START_VAL, LIMIT and `dir` when enabled.
- Top level holds the FSM, the count, pass and tc registers, and the priority logic.

## Test plan
Parameters for all scenarios: WIDTH=10, STEP=2, START_VAL=0, LIMIT=6, PASSES=2.
- Reset: assert reset low mid-run at count=4 -> count=0, tc=0, pass=0, busy=0, done=0 immediately; after release, enable is ignored in IDLE.
- Full run: start, then 8 enables -> count 2,4,6,0(tc=1,pass=1),2,4,6,0(tc=1,pass=2); done=1, busy=0; further enables keep count=0.
- Load and wrap: in RUN, load load_val=5, then enable -> count=5, then 7>6 so count=0, tc=1, pass=1.
- Abort and restart: stop at count=4 -> IDLE, count=0. start together with enable -> count=0 (enable not applied), busy=1.
- Non-aligned limit: LIMIT=5, STEP=2, enables from 0 -> 2, 4, 0 with tc=1.
- `STRIDE_CNT_DOWN_EN` with dir=1 from start: enables -> count 6 with tc=1 and pass=1, then 4, 2, 0, then 6 with tc=1, pass=2 and done=1.
